// File: rtl/rand_pkg.sv
// Shared constants for the bounded random-draw block: word widths and FSM encoding.
package rand_pkg;

  localparam int RAND_W = 5;
  localparam int TRY_W  = 4;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SAMPLE = 1'b1;

endpackage

// File: rtl/rand_accept.sv
// Combinational accept/reject decision and wrap-at-RANGE fallback value.
// With NO_REPEAT_EN defined, a sample equal to the previous draw is also rejected.
module rand_accept
  import rand_pkg::*;
#(
  parameter int RANGE = 20
) (
  input  logic [RAND_W-1:0] raw,
  input  logic [RAND_W-1:0] prev,
  output logic              accept,
  output logic [RAND_W-1:0] fallback_val
);

  // One extra bit so that RANGE=32 compares correctly against a 5-bit sample.
  localparam logic [RAND_W:0]   RANGE_X = (RAND_W + 1)'(RANGE);
  localparam logic [RAND_W-1:0] LAST    = RAND_W'(RANGE - 1);

  logic in_range;
  logic not_repeat;

  assign in_range = ({1'b0, raw} < RANGE_X);

`ifdef NO_REPEAT_EN
  // A single-outcome range can only ever produce 0, so the repeat rule is bypassed.
  assign not_repeat = (RANGE == 1) || (raw != prev);
`else
  assign not_repeat = 1'b1;
`endif

  assign accept       = in_range && not_repeat;
  assign fallback_val = (prev == LAST) ? '0 : prev + RAND_W'(1);

endmodule

// File: rtl/rand_range_draw.sv
// Bounded random draw in [0, RANGE-1] by rejection sampling with a bounded retry
// count and a deterministic fallback. Optional macro: NO_REPEAT_EN.
//
// Handshake: req is level-sampled only in IDLE; busy is high from the cycle after
// an accepted req until the draw completes; valid pulses for exactly one cycle
// when value is updated. A req seen while busy is dropped, not queued.
module rand_range_draw
  import rand_pkg::*;
#(
  parameter int RANGE     = 20,
  parameter int MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RAND_W-1:0] raw,
  input  logic              req,
  output logic              busy,
  output logic              valid,
  output logic [RAND_W-1:0] value,
  output logic [TRY_W-1:0]  tries,
  output logic              stuck
);

  localparam logic [TRY_W-1:0] LAST_TRY = TRY_W'(MAX_TRIES - 1);

  logic [0:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [RAND_W-1:0] value_q, value_d;
  logic [RAND_W-1:0] prev_q, prev_d;
  logic [TRY_W-1:0]  tries_q, tries_d;
  logic              stuck_q, stuck_d;
  logic              zero_q, zero_d;

  logic              accept;
  logic [RAND_W-1:0] fallback_val;

  rand_accept #(
    .RANGE(RANGE)
  ) u_accept (
    .raw         (raw),
    .prev        (prev_q),
    .accept      (accept),
    .fallback_val(fallback_val)
  );

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    value_d = value_q;
    prev_d  = prev_q;
    tries_d = tries_q;
    stuck_d = stuck_q;
    zero_d  = zero_q;
    if (state_q == ST_IDLE) begin
      if (req) begin
        state_d = ST_SAMPLE;
        busy_d  = 1'b1;
        tries_d = '0;
      end
    end else begin
      // zero_q remembers the previous SAMPLE cycle only; idle cycles leave it alone.
      zero_d = (raw == '0);
      if (zero_q && (raw == '0)) stuck_d = 1'b1;
      if (accept) begin
        value_d = raw;
        prev_d  = raw;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else if (tries_q == LAST_TRY) begin
        value_d = fallback_val;
        prev_d  = fallback_val;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end else begin
        tries_d = tries_q + TRY_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      value_q <= '0;
      prev_q  <= '0;
      tries_q <= '0;
      stuck_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      value_q <= value_d;
      prev_q  <= prev_d;
      tries_q <= tries_d;
      stuck_q <= stuck_d;
      zero_q  <= zero_d;
    end
  end

  assign busy  = busy_q;
  assign valid = valid_q;
  assign value = value_q;
  assign tries = tries_q;
  assign stuck = stuck_q;

endmodule

// File: tb/tb_rand_range_draw.sv
// Self-checking bench for rand_range_draw (RANGE=20, MAX_TRIES=8) with a
// draw-level reference model feeding an expected-value queue.
module tb_rand_range_draw;
  import rand_pkg::*;

  localparam int RANGE     = 20;
  localparam int MAX_TRIES = 8;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       req   = 1'b0;
  logic [4:0] raw   = 5'd0;
  logic       busy;
  logic       valid;
  logic [4:0] value;
  logic [3:0] tries;
  logic       stuck;

  always #5 clk = ~clk;

  rand_range_draw #(
    .RANGE    (RANGE),
    .MAX_TRIES(MAX_TRIES)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (raw),
    .req  (req),
    .busy (busy),
    .valid(valid),
    .value(value),
    .tries(tries),
    .stuck(stuck)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [4:0] exp_q[$];
  logic [3:0] exp_t_q[$];
  int         exp_c_q[$];

  logic [4:0] seq[0:15];
  int         seq_n = 1;
  logic [4:0] m_prev = 5'd0;

  function automatic logic [4:0] seq_at(int k);
    return seq[(k < seq_n) ? k : seq_n - 1];
  endfunction

  // Reference model: walks the planned raw sequence one SAMPLE edge at a time.
  task automatic model_push();
    logic [4:0] v;
    logic [3:0] t;
    logic [4:0] r;
    bit         done;
    bit         ok;
    int         c;
    v = 5'd0; t = 4'd0; done = 1'b0; c = 0;
    for (int k = 0; k < MAX_TRIES && !done; k++) begin
      r  = seq_at(k);
      c  = k + 1;
      ok = (int'(r) < RANGE);
`ifdef NO_REPEAT_EN
      if (RANGE > 1 && r == m_prev) ok = 1'b0;
`endif
      if (ok) begin
        v = r; done = 1'b1;
      end else if (k == MAX_TRIES - 1) begin
        v = (int'(m_prev) == RANGE - 1) ? 5'd0 : 5'(m_prev + 5'd1);
        done = 1'b1;
      end else begin
        t = t + 4'd1;
      end
    end
    m_prev = v;
    exp_q.push_back(v);
    exp_t_q.push_back(t);
    exp_c_q.push_back(c);
  endtask

  // Runs one draw from IDLE; call at posedge+1.
  task automatic run_draw(input string name);
    int         cyc;
    bit         got;
    logic [4:0] ev;
    logic [3:0] et;
    int         ec;
    model_push();
    req = 1'b1;
    raw = seq_at(0);
    @(posedge clk); #1;
    req = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL %s busy_start: got %b want 1", name, busy);
    end
    cyc = 0; got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (valid === 1'b1) got = 1'b1;
      else raw = seq_at(cyc);
    end
    ev = exp_q.pop_front();
    et = exp_t_q.pop_front();
    ec = exp_c_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++; $display("FAIL %s timeout: no valid in 40 cycles, want after %0d", name, ec);
    end else begin
      if (value !== ev) begin
        n_err++; $display("FAIL %s value: got %0d want %0d", name, value, ev);
      end
      n_cmp++;
      if (tries !== et) begin
        n_err++; $display("FAIL %s tries: got %0d want %0d", name, tries, et);
      end
      n_cmp++;
      if (cyc != ec) begin
        n_err++; $display("FAIL %s latency: got %0d want %0d", name, cyc, ec);
      end
      n_cmp++;
      if (busy !== 1'b0) begin
        n_err++; $display("FAIL %s busy_end: got %b want 0", name, busy);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if (valid !== 1'b0) begin
      n_err++; $display("FAIL %s valid_pulse: got %b want 0", name, valid);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_cmp++;
    if ({busy, valid, value, tries, stuck} !== 12'd0) begin
      n_err++;
      $display("FAIL %s: busy=%b valid=%b value=%0d tries=%0d stuck=%b want all 0",
               name, busy, valid, value, tries, stuck);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b1; raw = 5'd3;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_held");
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++; $display("FAIL reset_state: got %b want %b", dut.state_q, ST_IDLE);
    end
    req = 1'b0;
    rst_n = 1'b1;
    m_prev = 5'd0;
    @(posedge clk); #1;
    check_idle_outputs("reset_release");
  endtask

  task automatic test_basic();
    seq[0] = 5'd5; seq_n = 1;
    run_draw("basic");
  endtask

  task automatic test_reject();
    seq[0] = 5'd25; seq[1] = 5'd30; seq[2] = 5'd7; seq_n = 3;
    run_draw("reject");
  endtask

  task automatic test_fallback();
    seq[0] = 5'd19; seq_n = 1;
    run_draw("fb_prime");
    seq[0] = 5'd31; seq_n = 1;
    run_draw("fallback_wrap");
    seq[0] = 5'd20; seq_n = 1;
    run_draw("fallback_inc");
  endtask

  task automatic test_req_busy();
    int nv;
    logic [4:0] ev;
    seq[0] = 5'd25; seq[1] = 5'd26; seq[2] = 5'd27; seq[3] = 5'd3; seq_n = 4;
    model_push();
    void'(exp_t_q.pop_back());
    void'(exp_c_q.pop_back());
    req = 1'b1; raw = seq_at(0);
    @(posedge clk); #1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      raw = seq_at(c);
      req = (c < 2);
      @(posedge clk); #1;
      if (valid === 1'b1) begin
        nv++;
        if (exp_q.size() > 0) begin
          ev = exp_q.pop_front();
          n_cmp++;
          if (value !== ev) begin
            n_err++; $display("FAIL req_busy value: got %0d want %0d", value, ev);
          end
        end
      end
    end
    req = 1'b0;
    n_cmp++;
    if (nv != 1) begin
      n_err++; $display("FAIL req_busy valid_count: got %0d want 1", nv);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [4:0] ev;
    bit         want_v;
    req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      want_v = (i % 2 == 0);
      if (want_v) begin
        seq[0] = 5'((int'(m_prev) + 5) % RANGE); seq_n = 1;
        model_push();
        void'(exp_t_q.pop_back());
        void'(exp_c_q.pop_back());
        raw = seq[0];
      end else begin
        raw = 5'($urandom_range(0, 31));
      end
      @(posedge clk); #1;
      if (i == 8) req = 1'b0;
      n_cmp++;
      if (valid !== want_v) begin
        n_err++; $display("FAIL b2b valid edge %0d: got %b want %b", i, valid, want_v);
      end
      if (want_v) begin
        ev = exp_q.pop_front();
        n_cmp++;
        if (value !== ev) begin
          n_err++; $display("FAIL b2b value edge %0d: got %0d want %0d", i, value, ev);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    for (int d = 0; d < 12; d++) begin
      for (int k = 0; k < 16; k++) seq[k] = 5'($urandom_range(0, 31));
      seq_n = 16;
      run_draw($sformatf("random%0d", d));
    end
  endtask

  task automatic test_async_reset();
    seq[0] = 5'd25; seq_n = 1;
    req = 1'b1; raw = 5'd25;
    @(posedge clk); #1;
    req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (busy !== 1'b1 || tries !== 4'd2) begin
      n_err++; $display("FAIL async_pre: busy=%b tries=%0d want 1/2", busy, tries);
    end
    #3 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    n_cmp++;
    if (dut.state_q !== ST_IDLE) begin
      n_err++; $display("FAIL async_reset_state: got %b want %b", dut.state_q, ST_IDLE);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_prev = 5'd0;
    @(posedge clk); #1;
    check_idle_outputs("async_release");
  endtask

  task automatic test_stuck();
    seq[0] = 5'd0; seq_n = 1;
    run_draw("stuck_first");
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL stuck_single: got %b want 0", stuck);
    end
    run_draw("stuck_second");
    n_cmp++;
    if (stuck !== 1'b1) begin
      n_err++; $display("FAIL stuck_set: got %b want 1", stuck);
    end
    seq[0] = 5'd5; seq_n = 1;
    run_draw("stuck_after");
    n_cmp++;
    if (stuck !== 1'b1) begin
      n_err++; $display("FAIL stuck_sticky: got %b want 1", stuck);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (stuck !== 1'b0) begin
      n_err++; $display("FAIL stuck_reset: got %b want 0", stuck);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_prev = 5'd0;
  endtask

`ifdef NO_REPEAT_EN
  task automatic test_no_repeat();
    seq[0] = 5'd7; seq_n = 1;
    run_draw("norep_prime");
    seq[0] = 5'd7; seq[1] = 5'd3; seq_n = 2;
    run_draw("norep");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_fallback();
    test_req_busy();
    test_back_to_back();
    test_random();
`ifdef NO_REPEAT_EN
    test_no_repeat();
`endif
    test_async_reset();
    test_stuck();
    test_basic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
